// File: rtl/serializer_pkg.sv
// Shared constants for the word serializer: FSM state encoding and default sizing.
package serializer_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_reg_pl.sv
// Parallel-load shift register built from individual D flip-flops.
// Load has priority over shift. Shifting fills the vacated end with zero.
module shift_reg_pl #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic             i_lsb_first,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] r_q;

   always_comb begin
      w_d = r_q;
      if (i_load)
         w_d = i_din;
      else if (i_shift)
         w_d = i_lsb_first ? {1'b0, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], 1'b0};
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            r_q[g] <= 1'b0;
         else
            r_q[g] <= w_d[g];
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/word_serializer_32.sv
// Parallel-in, serial-out word transmitter with load/ready and valid/hold handshakes.
// state    | meaning
// ST_IDLE  | READY high, waiting for L
// ST_SHIFT | presenting one word bit per accepted cycle
// ST_DONE  | one-cycle DONE pulse, then back to idle
module word_serializer_32
   import serializer_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int LSB_FIRST = 1,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             C,
   input  logic             nR,
   input  logic             L,
   input  logic [WIDTH-1:0] DIN,
   input  logic             HOLD,
   output logic             READY,
   output logic             SOUT,
   output logic             SVALID,
   output logic             SFIRST,
   output logic             SLAST,
   output logic             DONE
);

   localparam logic             LSB      = (LSB_FIRST != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic [WIDTH-1:0] w_shreg;

   shift_reg_pl #(.WIDTH(WIDTH)) u_shreg (
      .i_clk       (C),
      .i_rst_n     (nR),
      .i_load      (w_load),
      .i_shift     (w_shift),
      .i_lsb_first (LSB),
      .i_din       (DIN),
      .o_q         (w_shreg)
   );

   assign w_last = (r_cnt == CNT_LAST);

   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (L) begin
               w_load      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!HOLD) begin
               w_shift = 1'b1;
               if (w_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Every output comes from registered state only, so L/DIN/HOLD never reach them directly.
   assign READY  = (r_state == ST_IDLE);
   assign SVALID = (r_state == ST_SHIFT);
   assign SOUT   = SVALID & (LSB ? w_shreg[0] : w_shreg[WIDTH-1]);
   assign SFIRST = SVALID & (r_cnt == '0);
   assign SLAST  = SVALID & w_last;
   assign DONE   = (r_state == ST_DONE);

endmodule

// File: tb/tb_word_serializer_32.sv
// Drives an LSB-first and an MSB-first serializer with identical stimulus and checks
// both against a word/bit-index reference model every cycle.
module tb_word_serializer_32;

   localparam int W = 32;

   logic         C = 1'b0;
   logic         nR = 1'b0;
   logic         L = 1'b0;
   logic [W-1:0] DIN = '0;
   logic         HOLD = 1'b0;

   logic rdy_l, sout_l, sval_l, sfst_l, slst_l, done_l;
   logic rdy_m, sout_m, sval_m, sfst_m, slst_m, done_m;

   int total = 0;
   int bad   = 0;

   // reference model: 0 idle, 1 sending, 2 done pulse
   int           m_mode = 0;
   int           m_idx  = 0;
   logic [W-1:0] m_word = '0;

   always #5 C = ~C;

   word_serializer_32 #(.WIDTH(W), .LSB_FIRST(1), .CNT_W(5)) u_lsb (
      .C(C), .nR(nR), .L(L), .DIN(DIN), .HOLD(HOLD),
      .READY(rdy_l), .SOUT(sout_l), .SVALID(sval_l),
      .SFIRST(sfst_l), .SLAST(slst_l), .DONE(done_l)
   );

   word_serializer_32 #(.WIDTH(W), .LSB_FIRST(0), .CNT_W(5)) u_msb (
      .C(C), .nR(nR), .L(L), .DIN(DIN), .HOLD(HOLD),
      .READY(rdy_m), .SOUT(sout_m), .SVALID(sval_m),
      .SFIRST(sfst_m), .SLAST(slst_m), .DONE(done_m)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic sending;
      sending = (m_mode == 1);
      chk("lsb_ready",  rdy_l,  m_mode == 0);
      chk("lsb_svalid", sval_l, sending);
      chk("lsb_sout",   sout_l, sending ? m_word[m_idx] : 1'b0);
      chk("lsb_sfirst", sfst_l, sending && m_idx == 0);
      chk("lsb_slast",  slst_l, sending && m_idx == W-1);
      chk("lsb_done",   done_l, m_mode == 2);
      chk("msb_ready",  rdy_m,  m_mode == 0);
      chk("msb_svalid", sval_m, sending);
      chk("msb_sout",   sout_m, sending ? m_word[W-1-m_idx] : 1'b0);
      chk("msb_sfirst", sfst_m, sending && m_idx == 0);
      chk("msb_slast",  slst_m, sending && m_idx == W-1);
      chk("msb_done",   done_m, m_mode == 2);
   endtask

   // advance the model with the inputs presented before the edge, then compare after it
   task automatic tick();
      if (!nR) begin
         m_mode = 0;
         m_idx  = 0;
      end else begin
         case (m_mode)
            0: if (L) begin m_word = DIN; m_idx = 0; m_mode = 1; end
            1: if (!HOLD) begin
                  if (m_idx == W-1) begin m_mode = 2; m_idx = 0; end
                  else m_idx++;
               end
            default: m_mode = 0;
         endcase
      end
      @(posedge C);
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic async_reset();
      #2;
      nR = 1'b0;
      #1;
      m_mode = 0;
      m_idx  = 0;
      check_all();
   endtask

   initial begin
      int cnt;
      logic seen;

      // reset held for two cycles, then idle
      #1;
      check_all();
      ticks(2);
      nR = 1'b1;
      ticks(5);

      // basic LSB-first word; MSB-first instance sees the same word
      DIN = 32'hA5A5_0F0F; L = 1'b1;
      tick();
      L = 1'b0; DIN = '0;
      ticks(W + 2);

      // word with distinct first and last bits for MSB-first ordering
      DIN = 32'h8000_0001; L = 1'b1;
      tick();
      L = 1'b0;
      ticks(W + 2);

      // back-pressure: three HOLD cycles on bit 1, DONE must come 35 edges after load
      DIN = 32'h0000_0003; L = 1'b1;
      tick();
      L = 1'b0;
      cnt = 0;
      tick(); cnt++;
      HOLD = 1'b1;
      ticks(3); cnt += 3;
      HOLD = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick(); cnt++;
         if (done_l) seen = 1'b1;
      end
      total++;
      assert (seen && cnt == W + 3) else begin
         bad++;
         $error("FAIL hold_latency observed=%0d expected=%0d (done_seen=%b)", cnt, W + 3, seen);
      end
      ticks(2);

      // HOLD on the last bit delays DONE
      DIN = 32'h8000_0000; L = 1'b1;
      tick();
      L = 1'b0;
      ticks(W - 1);
      HOLD = 1'b1;
      ticks(4);
      HOLD = 1'b0;
      ticks(3);

      // load ignored mid-word, L held so a new word starts on return to idle, DIN then changes
      DIN = '0; L = 1'b1;
      tick();
      L = 1'b0;
      ticks(10);
      DIN = 32'hFFFF_FFFF; L = 1'b1;
      ticks(W - 10 + 2);
      DIN = 32'h1234_5678;
      tick();
      L = 1'b0;
      ticks(W + 2);

      // reset at bit 16 aborts the word without a DONE pulse
      DIN = 32'hFFFF_FFFF; L = 1'b1;
      tick();
      L = 1'b0;
      ticks(16);
      async_reset();
      ticks(2);
      #2 nR = 1'b1;
      DIN = 32'h0000_0001; L = 1'b1;
      tick();
      L = 1'b0;
      ticks(W + 2);

      // randomized traffic with occasional asynchronous reset
      for (int i = 0; i < 600; i++) begin
         L    = ($urandom_range(0, 3) == 0);
         DIN  = $urandom;
         HOLD = ($urandom_range(0, 3) == 0);
         if (i == 250 || i == 470) begin
            async_reset();
            tick();
            #2 nR = 1'b1;
         end else begin
            tick();
         end
      end
      L = 1'b0; HOLD = 1'b0;
      ticks(W + 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/word_serializer_32.md
Name: word_serializer_32

Overview:
Parallel-in, serial-out transmitter that takes a 32-bit register word and shifts it out one bit per clock on a single data line. It is the sending end of the serial bit stream that our D_FF shift chains and REG1-based capture registers consume. It sits between a REG1/register-bank read port and any serial receiver. It uses a load/ready handshake on the parallel side and a valid/hold handshake on the serial side.

Parameters:
WIDTH, 32, word width in bits; must be 2 or more.
LSB_FIRST, 1, 1 shifts bit 0 out first; 0 shifts bit WIDTH-1 out first.
CNT_W, 5, bit-counter width; must equal ceil(log2(WIDTH)).

Ports:
C  input  1  system clock; all state changes on the rising edge.
nR  input  1  asynchronous active-low reset.
L  input  1  load strobe; sampled on the rising edge of C.
DIN  input  WIDTH  parallel word; captured when a load is accepted.
HOLD  input  1  receiver back-pressure; 1 freezes the current serial bit.
READY  output  1  block is idle and will accept L.
SOUT  output  1  serial data bit.
SVALID  output  1  SOUT carries a word bit.
SFIRST  output  1  marks the first bit of a word.
SLAST  output  1  marks the last bit of a word.
DONE  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Interface: one clock, C; reset nR is asynchronous and active-low.
- Reset (nR=0, takes effect immediately, independent of C):
  - state=IDLE, shift register=0, count=0.
  - READY=1, SOUT=0, SVALID=0, SFIRST=0, SLAST=0, DONE=0.
- State machine: IDLE, SHIFT, DONE_ST. Encoding is 2 bits, from the package.
- IDLE:
  - READY=1, SVALID=0, SOUT=0.
  - Rising edge with L=1: capture DIN into the shift register, count=0, go to SHIFT.
  - HOLD is ignored in IDLE.
- SHIFT:
  - READY=0, SVALID=1.
  - SOUT = shreg[0] when LSB_FIRST=1, otherwise shreg[WIDTH-1].
  - SFIRST=1 when count=0. SLAST=1 when count=WIDTH-1.
  - Rising edge with HOLD=0: the current bit is accepted; shift one position (zero fill) and count+1.
  - Rising edge with HOLD=1: nothing changes and SOUT is held.
  - Rising edge with HOLD=0 and count=WIDTH-1: go to DONE_ST; count wraps to 0.
- DONE_ST:
  - DONE=1, SVALID=0, READY=0.
  - Always returns to IDLE on the next edge; HOLD and L are ignored.
- Outputs are decoded from registered state only; there is no combinational path from L/DIN/HOLD to the outputs.
- Latency with no HOLD, load accepted at edge k:
  - bit i is valid in the cycle after edge k+i;
  - DONE is high after edge k+WIDTH;
  - READY returns after edge k+WIDTH+1.
  - Minimum word period is WIDTH+2 cycles.
  - Each HOLD cycle during SHIFT adds exactly one cycle.
- Boundary rules:
  - L while not in IDLE is ignored; no queueing, and DIN is not sampled.
  - L=1 held continuously: a new word loads each time IDLE is reached.
  - DIN changing after capture has no effect on the word in flight.
  - HOLD asserted on the SLAST cycle delays DONE until HOLD drops.
  - nR asserted mid-word aborts the word. SVALID drops without waiting for a clock. No DONE is issued.
  - After nR is released, the first edge with L=1 starts a clean word.

Decomposition:
- Package serializer_pkg holds:
  - state constants ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10;
  - the defaults WIDTH=32 and CNT_W=5.
- One sub-module, shift_reg_pl: WIDTH-bit parallel-load shift register with load enable, shift enable, direction select and async active-low clear on nR. It is built from D_FF-style bits.
- The FSM, counter and output decode stay in word_serializer_32.

Test Plan:
- Reset then idle: pulse nR low for 2 cycles -> READY=1, SVALID=0, SOUT=0, DONE=0; no change over 5 idle cycles.
- Basic word: L=1 with DIN=32'hA5A5_0F0F, LSB_FIRST=1, HOLD=0 -> SOUT sequence 1,1,1,1,0,0,0,0,... (bits 0..31) over 32 cycles; SFIRST on bit 0, SLAST on bit 31; DONE 1 cycle later; READY 1 cycle after that.
- MSB-first: LSB_FIRST=0, DIN=32'h8000_0001 -> first bit 1, then 30 zeros, last bit 1.
- Back-pressure: DIN=32'h0000_0003, HOLD=1 for 3 cycles starting at bit 1 -> SOUT stays 1 for 4 cycles; total load-to-DONE is 35 cycles.
- Ignored load: assert L with DIN=32'hFFFF_FFFF at bit 10 of word 32'h0 -> all 32 bits are 0; READY stays 0 until after DONE.
- Mid-word reset: nR=0 at bit 16 of 32'hFFFF_FFFF -> SVALID=0 immediately, no DONE pulse; after release, L with 32'h1 gives a clean word with bit 0 = 1.
